// File: rtl/rr_arbiter4.sv
// rr_arbiter4: 4-requester round-robin arbiter with a registered one-hot grant.
// The owner keeps the grant until it drops its request. The next owner is then
// searched from the slot after the releasing owner, on the same edge.
// Optional feature macro: GRANT_TIMEOUT_EN forces rotation after MAX_HOLD
// consecutive grant cycles when another requester is waiting.
module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       tout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Last meaningful hold count; the counter never needs to go past it.
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [1:0]       next_base;

  // One-hot winner: first set bit of r in the order base, base+1, base+2, base+3.
  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [3:0] pick;
    logic [1:0] idx;
    pick = '0;
    // Scan from the far end so the nearest set bit is the one left standing.
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (r[idx]) pick = 4'b0001 << idx;
    end
    return pick;
  endfunction

  // Binary index and validity are pure decodes of the grant register.
  always_comb begin
    gnt_idx = 2'd0;
    unique case (gnt_q)
      4'b0001: gnt_idx = 2'd0;
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_valid = (gnt_q != 4'd0) && ((gnt_q & (gnt_q - 4'd1)) == 4'd0);
  assign next_base = gnt_idx + 2'd1;

`ifdef GRANT_TIMEOUT_EN
  logic tout_q, tout_d;
  assign tout = tout_q;
`else
  assign tout = 1'b0;
`endif

  // Next-state: arbitrate in idle, hold or hand over in busy.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
`ifdef GRANT_TIMEOUT_EN
    tout_d  = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (req != 4'd0) begin
          gnt_d   = rr_pick(req, ptr_q);
          hold_d  = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if ((req & gnt_q) == 4'd0) begin
          // Release: hand over back-to-back, or fall idle if nobody waits.
          ptr_d  = next_base;
          gnt_d  = rr_pick(req, next_base);
          hold_d = '0;
          if (req == 4'd0) state_d = StIdle;
        end else begin
`ifdef GRANT_TIMEOUT_EN
          if (hold_q == HoldLast) begin
            hold_d = '0;
            if ((req & ~gnt_q) != 4'd0) begin
              ptr_d  = next_base;
              gnt_d  = rr_pick(req & ~gnt_q, next_base);
              tout_d = 1'b1;
            end
          end else begin
            hold_d = hold_q + CNT_W'(1);
          end
`else
          if (hold_q != HoldLast) hold_d = hold_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  // Forced-rotation pulse register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tout_q <= 1'b0;
    else        tout_q <= tout_d;
  end
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: scoreboard bench for rr_arbiter4. A stimulus process drives req
// on the falling edge and queues the expected outputs from a behavioural model;
// a monitor pops and compares one entry after every rising edge.
module tb_rr_arbiter4;

  localparam int MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       tout;

  rr_arbiter4 #(
    .MAX_HOLD(MaxHold),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .tout     (tout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] idx;
    logic       valid;
    logic       tout;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   release_pending = 1'b0;

  // Model state: current owner (-1 = none), priority pointer, cycles held.
  int   m_own = -1;
  int   m_ptr = 0;
  int   m_hold = 0;
  bit   m_tout = 1'b0;

  function automatic int pick(input logic [3:0] r, input int base);
    for (int k = 0; k < 4; k++) begin
      if (r[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  // Advance the model over one rising edge with request vector r.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] others;
    m_tout = 1'b0;
    if (!rst_n) begin
      m_own = -1; m_ptr = 0; m_hold = 0;
    end else if (m_own < 0) begin
      if (r != 4'd0) begin
        m_own = pick(r, m_ptr); m_hold = 0;
      end
    end else if (!r[m_own]) begin
      m_ptr  = (m_own + 1) % 4;
      m_own  = (r != 4'd0) ? pick(r, m_ptr) : -1;
      m_hold = 0;
    end else begin
`ifdef GRANT_TIMEOUT_EN
      if (m_hold == MaxHold - 1) begin
        others = r & ~(4'b0001 << m_own);
        m_hold = 0;
        if (others != 4'd0) begin
          m_ptr  = (m_own + 1) % 4;
          m_own  = pick(others, m_ptr);
          m_tout = 1'b1;
        end
      end else begin
        m_hold++;
      end
`else
      others = 4'd0;
      m_hold = m_hold + 1 + int'(others);
`endif
    end
  endtask

  // Drive one cycle of stimulus and queue what the next rising edge must show.
  task automatic step(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    if (release_pending) begin
      rst_n = 1'b1;
      release_pending = 1'b0;
    end
    req = r;
    model_step(r);
    e.gnt   = (m_own < 0) ? 4'd0 : (4'b0001 << m_own);
    e.idx   = (m_own < 0) ? 2'd0 : 2'(m_own);
    e.valid = (m_own >= 0);
    e.tout  = m_tout;
    exp_q.push_back(e);
  endtask

  // Pulse reset low between edges and check the grant drops with no clock.
  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    cmp("async_gnt", gnt, 4'd0);
    cmp("async_valid", {3'd0, gnt_valid}, 4'd0);
    cmp("async_idx", {2'd0, gnt_idx}, 4'd0);
    m_own = -1; m_ptr = 0; m_hold = 0; m_tout = 1'b0;
    release_pending = 1'b1;
  endtask

  // Monitor: compare every output against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("gnt", gnt, e.gnt);
        cmp("gnt_idx", {2'd0, gnt_idx}, {2'd0, e.idx});
        cmp("gnt_valid", {3'd0, gnt_valid}, {3'd0, e.valid});
        cmp("tout", {3'd0, tout}, {3'd0, e.tout});
      end
    end
  end

  initial begin
    logic [3:0] r;
    logic [3:0] flip;

    // Reset state with requests present: nothing may be granted.
    step(4'b1111);
    step(4'b1111);
    release_pending = 1'b1;

    // Single requester 2 from reset.
    step(4'b0100);
    step(4'b0100);
    step(4'b0000);
    step(4'b0000);

    // All requesting; each owner drops briefly so grants rotate back-to-back.
    for (int c = 0; c < 16; c++) begin
      r = 4'b1111;
      if (m_own >= 0 && m_hold == 1) r[m_own] = 1'b0;
      step(r);
    end
    step(4'b0000);
    step(4'b0000);

    // Owner 1 releases with 0 and 3 pending: 3 then 0.
    async_reset();
    step(4'b0010);
    step(4'b0010);
    step(4'b1001);
    step(4'b1001);
    step(4'b0001);
    step(4'b0001);
    step(4'b0000);

    // Reset while owner 1 holds; afterwards full request starts at 0.
    async_reset();
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);
    async_reset();
    step(4'b1111);
    step(4'b1111);

    // Two long holders, then a lone holder (rotation only with the timeout feature).
    async_reset();
    for (int c = 0; c < 12; c++) step(4'b0011);
    for (int c = 0; c < 8; c++) step(4'b0001);
    step(4'b0000);

    // Randomised phase with sticky requests and occasional resets.
    r = 4'd0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
      r = r ^ flip;
      if ($urandom_range(0, 49) == 0) r = 4'd0;
      if ($urandom_range(0, 199) == 0) async_reset();
      step(r);
    end

    step(4'd0);
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
